// File: rtl/fifo_byte_reader.sv
// fifo_byte_reader: pops 32-bit words from a word FIFO and serializes them
// as a valid/ready byte stream, marking the final byte of every word.
module fifo_byte_reader #(
   parameter int BYTES_PER_WORD = 4,
   parameter bit LSB_FIRST      = 1'b1
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        en_in,
   input  logic        fifo_empty_in,
   input  logic [31:0] fifo_data_in,
   output logic        fifo_deq_out,
   output logic [7:0]  m_data_out,
   output logic        m_valid_out,
   input  logic        m_ready_in,
   output logic        m_last_out,
   output logic        busy_out,
   output logic [15:0] words_done_out
);

   typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   state_t      state_q, state_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] word_q, word_d;
   logic [15:0] words_done_q, words_done_d;
   logic        deq_q, deq_d;
   logic        busy_q, busy_d;

   logic        pop_ok;
   logic        in_send;
   logic        is_last;
   logic        accept;
   logic [1:0]  sel_idx;

   assign pop_ok  = en_in && !fifo_empty_in;
   assign in_send = (state_q == SEND);
   assign is_last = (byte_idx_q == LAST_IDX);
   assign accept  = in_send && m_ready_in;
   assign sel_idx = LSB_FIRST ? byte_idx_q : (LAST_IDX - byte_idx_q);

   assign fifo_deq_out   = deq_q;
   assign busy_out       = busy_q;
   assign words_done_out = words_done_q;
   assign m_valid_out    = in_send;
   assign m_data_out     = in_send ? word_q[{sel_idx, 3'b000} +: 8] : 8'h00;
   assign m_last_out     = in_send && is_last;

   // Next-state logic: one pop in flight at a time, word captured in LOAD, bytes stepped on accept
   always_comb begin
      state_d      = state_q;
      byte_idx_d   = byte_idx_q;
      word_d       = word_q;
      words_done_d = words_done_q;
      case (state_q)
         IDLE: begin
            if (pop_ok) begin
               state_d = POP;
            end
         end
         POP: begin
            state_d = LOAD;
         end
         LOAD: begin
            word_d     = fifo_data_in;
            byte_idx_d = 2'd0;
            state_d    = SEND;
         end
         SEND: begin
            if (accept) begin
               if (is_last) begin
                  words_done_d = words_done_q + 16'd1;
                  byte_idx_d   = 2'd0;
                  state_d      = pop_ok ? POP : IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      deq_d  = (state_d == POP);
      busy_d = (state_d != IDLE);
   end

   // State and data registers; reset discards any word mid-serialization
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= IDLE;
         byte_idx_q   <= 2'd0;
         word_q       <= 32'd0;
         words_done_q <= 16'd0;
         deq_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         word_q       <= word_d;
         words_done_q <= words_done_d;
         deq_q        <= deq_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// tb_fifo_byte_reader: FIFO models plus byte scoreboards for a 4-byte LSB-first
// instance and a 2-byte MSB-first instance of fifo_byte_reader.
module tb_fifo_byte_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        ready = 1'b1;
   logic        fifo_empty = 1'b1;
   logic        fifo_empty2 = 1'b1;
   logic [31:0] fifo_data = 32'd0;
   logic [31:0] fifo_data2 = 32'd0;
   logic        deq, deq2, valid, valid2, last, last2, busy, busy2;
   logic [7:0]  data, data2;
   logic [15:0] done_cnt, done_cnt2;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] fq[$];
   logic [31:0] fq2[$];
   logic [8:0]  exp_q[$];
   logic [8:0]  exp2_q[$];
   logic [15:0] exp_done = 16'd0;
   int          accepts = 0;
   int          deq_count = 0;
   int          gap_len = 0;
   int          low_count = 0;
   logic        hold_prev = 1'b0;
   logic        valid_prev = 1'b0;
   logic        deq_prev = 1'b0;
   logic [7:0]  prev_data = 8'd0;
   logic        prev_last = 1'b0;
   logic        data_hold = 1'b0;
   logic        data_hold2 = 1'b0;

   typedef struct {
      logic [31:0] word;
      logic [7:0]  e0, e1, e2, e3;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   fifo_byte_reader #(.BYTES_PER_WORD(4), .LSB_FIRST(1'b1)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .fifo_empty_in(fifo_empty),
      .fifo_data_in(fifo_data), .fifo_deq_out(deq), .m_data_out(data),
      .m_valid_out(valid), .m_ready_in(ready), .m_last_out(last),
      .busy_out(busy), .words_done_out(done_cnt)
   );

   fifo_byte_reader #(.BYTES_PER_WORD(2), .LSB_FIRST(1'b0)) dut2 (
      .clk_in(clk), .rst_n_in(rst_n), .en_in(en), .fifo_empty_in(fifo_empty2),
      .fifo_data_in(fifo_data2), .fifo_deq_out(deq2), .m_data_out(data2),
      .m_valid_out(valid2), .m_ready_in(ready), .m_last_out(last2),
      .busy_out(busy2), .words_done_out(done_cnt2)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] word, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
      fq.push_back(word);
      fifo_empty = 1'b0;
      exp_q.push_back({1'b0, e0});
      exp_q.push_back({1'b0, e1});
      exp_q.push_back({1'b0, e2});
      exp_q.push_back({1'b1, e3});
   endtask

   task automatic pushWord2(input logic [31:0] word, input logic [7:0] e0, input logic [7:0] e1);
      fq2.push_back(word);
      fifo_empty2 = 1'b0;
      exp2_q.push_back({1'b0, e0});
      exp2_q.push_back({1'b1, e1});
   endtask

   task automatic waitDrain(input int budget, input bit rand_ready);
      bit done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (rand_ready) ready = 1'($urandom_range(0, 1));
         if (exp_q.size() == 0 && exp2_q.size() == 0 && fq.size() == 0 && fq2.size() == 0 &&
             !busy && !busy2) begin
            done = 1'b1;
            break;
         end
      end
      ready = 1'b1;
      checkOutput("drain_complete", 32'(done), 32'd1);
   endtask

   // FIFO model for the 4-byte instance: data_out loads during deq, holds through LOAD, then scrambles
   always @(negedge clk) begin
      if (deq) begin
         checkOutput("deq_when_nonempty", 32'(fq.size() != 0), 32'd1);
         if (fq.size() != 0) fifo_data = fq.pop_front();
         fifo_empty = (fq.size() == 0);
         data_hold = 1'b1;
      end else if (data_hold) begin
         data_hold = 1'b0;
      end else begin
         fifo_data = $urandom();
      end
   end

   // FIFO model for the 2-byte instance, same timing
   always @(negedge clk) begin
      if (deq2) begin
         checkOutput("deq2_when_nonempty", 32'(fq2.size() != 0), 32'd1);
         if (fq2.size() != 0) fifo_data2 = fq2.pop_front();
         fifo_empty2 = (fq2.size() == 0);
         data_hold2 = 1'b1;
      end else if (data_hold2) begin
         data_hold2 = 1'b0;
      end else begin
         fifo_data2 = $urandom();
      end
   end

   // Byte monitor for the 4-byte instance: scoreboard compare, hold stability, gap length, deq pulses
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev  = 1'b0;
         valid_prev = 1'b0;
         deq_prev   = 1'b0;
         low_count  = 0;
      end else begin
         if (hold_prev) begin
            checkOutput("hold_valid", 32'(valid), 32'd1);
            checkOutput("hold_data", 32'(data), 32'(prev_data));
            checkOutput("hold_last", 32'(last), 32'(prev_last));
         end
         if (deq) begin
            deq_count++;
            checkOutput("deq_single_cycle", 32'(deq_prev), 32'd0);
         end
         if (valid && !valid_prev) gap_len = low_count;
         if (valid) low_count = 0;
         else low_count++;
         if (valid && ready) begin
            accepts++;
            checkOutput("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               logic [8:0] e;
               e = exp_q.pop_front();
               checkOutput("byte_data", 32'(data), 32'(e[7:0]));
               checkOutput("byte_last", 32'(last), 32'(e[8]));
               if (e[8]) exp_done = exp_done + 16'd1;
            end
         end
         hold_prev  = valid && !ready;
         prev_data  = data;
         prev_last  = last;
         valid_prev = valid;
         deq_prev   = deq;
      end
   end

   // Byte monitor for the 2-byte MSB-first instance
   always @(negedge clk) begin
      if (rst_n && valid2 && ready) begin
         checkOutput("scoreboard2_nonempty", 32'(exp2_q.size() != 0), 32'd1);
         if (exp2_q.size() != 0) begin
            logic [8:0] e;
            e = exp2_q.pop_front();
            checkOutput("byte2_data", 32'(data2), 32'(e[7:0]));
            checkOutput("byte2_last", 32'(last2), 32'(e[8]));
         end
      end
   end

   // Test sequence
   initial begin
      int  d0;
      int  base_acc;
      bit  found;
      logic [31:0] w;

      vecs[0] = '{32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
      vecs[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80};
      vecs[4] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12};

      // Power-on reset values
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_deq", 32'(deq), 32'd0);
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done_cnt), 32'd0);
      checkOutput("rst2_valid", 32'(valid2), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idle_no_pop", 32'(deq_count), 32'd0);

      // Single-word vectors with latency and consecutive-byte timing
      for (int v = 0; v < 5; v++) begin
         @(posedge clk); #1;
         applyStimulus(vecs[v].word, vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
         @(negedge clk);
         checkOutput("pre_pop_deq", 32'(deq), 32'd0);
         @(negedge clk);
         checkOutput("pop_deq", 32'(deq), 32'd1);
         checkOutput("pop_busy", 32'(busy), 32'd1);
         @(negedge clk);
         checkOutput("load_deq", 32'(deq), 32'd0);
         checkOutput("load_valid", 32'(valid), 32'd0);
         @(negedge clk);
         checkOutput("first_byte", 32'(data), 32'(vecs[v].e0));
         for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checkOutput("byte_valid", 32'(valid), 32'd1);
         end
         checkOutput("last_flag", 32'(last), 32'd1);
         @(negedge clk);
         checkOutput("end_valid", 32'(valid), 32'd0);
         checkOutput("end_busy", 32'(busy), 32'd0);
         checkOutput("words_done", 32'(done_cnt), 32'(exp_done));
      end
      checkOutput("pop_count", 32'(deq_count), 32'd5);

      // MSB-first two-byte instance
      @(posedge clk); #1;
      pushWord2(32'h0000BEEF, 8'hBE, 8'hEF);
      pushWord2(32'h12345678, 8'h56, 8'h78);
      waitDrain(100, 1'b0);
      checkOutput("words_done2", 32'(done_cnt2), 32'd2);

      // Backpressure across 8 words
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         w = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
         applyStimulus(w, w[7:0], w[15:8], w[23:16], w[31:24]);
      end
      waitDrain(800, 1'b1);
      checkOutput("bp_words_done", 32'(done_cnt), 32'(exp_done));

      // Back-to-back words with enable dropped on the second word's first byte
      @(posedge clk); #1;
      base_acc = accepts;
      d0 = deq_count;
      applyStimulus(32'h11223344, 8'h44, 8'h33, 8'h22, 8'h11);
      applyStimulus(32'h55667788, 8'h88, 8'h77, 8'h66, 8'h55);
      applyStimulus(32'h99AABBCC, 8'hCC, 8'hBB, 8'hAA, 8'h99);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (valid && accepts == base_acc + 4) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("second_word_reached", 32'(found), 32'd1);
      en = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (accepts == base_acc + 8 && !busy) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("second_word_done", 32'(found), 32'd1);
      checkOutput("word_gap", 32'(gap_len), 32'd2);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("no_pop_disabled", 32'(deq_count - d0), 32'd2);
      checkOutput("idle_disabled", 32'(busy), 32'd0);
      en = 1'b1;
      waitDrain(100, 1'b0);
      checkOutput("third_pop", 32'(deq_count - d0), 32'd3);

      // Asynchronous reset mid-SEND while the consumer stalls
      @(posedge clk); #1;
      ready = 1'b0;
      applyStimulus(32'hCAFEF00D, 8'h0D, 8'hF0, 8'hFE, 8'hCA);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (valid) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("stall_valid", 32'(found), 32'd1);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_deq", 32'(deq), 32'd0);
      checkOutput("arst_valid", 32'(valid), 32'd0);
      checkOutput("arst_data", 32'(data), 32'd0);
      checkOutput("arst_last", 32'(last), 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_done", 32'(done_cnt), 32'd0);
      exp_q.delete();
      fq.delete();
      fifo_empty = 1'b1;
      exp_done = 16'd0;
      ready = 1'b1;
      d0 = deq_count;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("post_reset_no_pop", 32'(deq_count - d0), 32'd0);
      checkOutput("post_reset_busy", 32'(busy), 32'd0);

      // Counter wrap from a preloaded count
      @(posedge clk); #1;
      force dut.words_done_q = 16'hFFFE;
      #1;
      release dut.words_done_q;
      exp_done = 16'hFFFE;
      @(negedge clk);
      checkOutput("wrap_preload", 32'(done_cnt), 32'h0000FFFE);
      @(posedge clk); #1;
      applyStimulus(32'h0BADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'h0B);
      waitDrain(100, 1'b0);
      checkOutput("wrap_ffff", 32'(done_cnt), 32'h0000FFFF);
      applyStimulus(32'hDEADC0DE, 8'hDE, 8'hC0, 8'hAD, 8'hDE);
      waitDrain(100, 1'b0);
      checkOutput("wrap_zero", 32'(done_cnt), 32'd0);
      checkOutput("wrap_model", 32'(exp_done), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_byte_reader.md
# fifo_byte_reader

Drain-side companion to the word FIFO: pops 32-bit words from the FIFO's dequeue port and re-emits them as a byte stream over a valid/ready handshake. It sits between a FIFO instance and a byte-wide consumer such as a UART transmitter or SPI shifter. It owns the FIFO `deq` strobe, captures the registered `data_out`, and serializes each word with a last-byte marker.

## Interface
- `BYTES_PER_WORD`, default 4 — bytes per FIFO word. Legal range 1–4. The FIFO word is 32 bits; with fewer than 4, only the low `8*BYTES_PER_WORD` bits are used.
- `LSB_FIRST`, default 1 — 1: byte 0 is `word[7:0]`. 0: byte 0 is the most significant used byte.
- `clk_in`  input  1  — single clock.
- `rst_n_in`  input  1  — reset, asynchronous, active-low.
- `en_in`  input  1  — when low, no new FIFO pop is issued; a word already popped finishes.
- `fifo_empty_in`  input  1  — FIFO `empty`.
- `fifo_data_in`  input  32  — FIFO `data_out`, registered by the FIFO on the edge that ends the `deq` cycle.
- `fifo_deq_out`  output  1  — FIFO `deq` strobe, registered, one cycle per pop.
- `m_data_out`  output  8  — byte out.
- `m_valid_out`  output  1  — byte valid.
- `m_ready_in`  input  1  — consumer accepts when `m_valid_out && m_ready_in` at a rising edge.
- `m_last_out`  output  1  — marks the final byte of the current word; valid only with `m_valid_out`.
- `busy_out`  output  1  — high in every state except IDLE.
- `words_done_out`  output  16  — count of fully transmitted words; wraps at 65535 → 0.

## Operation
- FSM states: IDLE, POP, LOAD, SEND.
- **IDLE:** if `en_in && !fifo_empty_in`, go to POP. Otherwise stay.
- **POP:** `fifo_deq_out = 1` for exactly this cycle. Next state is LOAD, unconditionally.
- **LOAD:** `fifo_data_in` now holds the popped word. Copy it into the internal word register, set `byte_idx = 0`, go to SEND.
- **SEND:** `m_valid_out = 1` and `m_data_out = selected byte(byte_idx)`.
  - Byte selection: `LSB_FIRST=1` gives `word[8*byte_idx +: 8]`. `LSB_FIRST=0` gives `word[8*(BYTES_PER_WORD-1-byte_idx) +: 8]`.
  - `m_last_out = (byte_idx == BYTES_PER_WORD-1)`.
  - On accept of a non-last byte: `byte_idx++`.
  - On accept of the last byte: `words_done_out++`. Then go to POP if `en_in && !fifo_empty_in`, else go to IDLE.
  - Without accept: hold all outputs stable. `m_data_out`, `m_last_out` and `m_valid_out` must not change while `m_valid_out && !m_ready_in`.
- `fifo_deq_out` is asserted only when the `fifo_empty_in` sampled in the preceding cycle was low. The FIFO is never popped while empty.
- At most one pop is in flight. A new pop never issues before the current word's last byte is accepted.
- The word register is the only data store. `fifo_data_in` may change after LOAD without affecting the bytes being sent.
- `en_in` falling during POP, LOAD or SEND has no effect on the in-flight word. It only blocks the next pop.
- Reset: asserting `rst_n_in` low immediately forces the following, regardless of the clock:
  - state = IDLE, `byte_idx = 0`, word register = 0, `words_done_out = 0`.
  - `fifo_deq_out = 0`, `m_valid_out = 0`, `m_data_out = 0`, `m_last_out = 0`, `busy_out = 0`.
  - A word that is mid-serialization is discarded. Deassertion is synchronized to `clk_in` outside this block.

## Timing
- Latency: `fifo_empty_in` low and `en_in` high sampled at edge E → `fifo_deq_out` high in cycle E..E+1 → LOAD in cycle E+1..E+2 → first byte valid from edge E+2.
- Throughput with `m_ready_in` held high: one word per `BYTES_PER_WORD + 2` cycles. Between words the pattern is SEND(last) → POP → LOAD → SEND, which puts exactly 2 cycles of `m_valid_out = 0` between bytes of consecutive words.
- `words_done_out` updates on the same edge that accepts the last byte.
- `busy_out` is a registered state decode. It goes low on the edge that enters IDLE.

## Test plan
- **Reset values:** drive `rst_n_in` low mid-SEND with no clock edge.
  - Required: all outputs 0 immediately.
  - After release with FIFO empty: stays IDLE, `fifo_deq_out` never pulses.
- **Single word, LSB first:** FIFO holds 0xA1B2C3D4, `m_ready_in = 1`.
  - Required: one `fifo_deq_out` pulse, then bytes D4, C3, B2, A1 on 4 consecutive cycles.
  - `m_last_out` high only on A1; `words_done_out = 1`.
- **MSB-first, `BYTES_PER_WORD = 2`:** word 0x0000BEEF.
  - Required: BE then EF, `m_last_out` on EF.
- **Backpressure:** toggle `m_ready_in` pseudo-randomly.
  - Required: the held byte is stable whenever valid is high and ready is low. No byte is dropped or duplicated across 8 words 0x00010203…
- **Back-to-back and enable:** three words queued, `en_in` dropped during the second word's first byte.
  - Required: the second word completes. No third pop until `en_in` returns.
  - Exactly a 2-cycle valid gap between words when enabled.
- **Counter wrap:** preload the scenario by sending 65536 words (or force the count).
  - Required: `words_done_out` reads 65535 → 0.
